// File: rtl/polar_decoder_pkg.sv
// Shared types for the SC polar decoder.
//   llr_t           : signed LLR sample at the default LLR width
//   f_sched_state_t : f-step layer scheduler FSM states
//   lanes_log2      : log2 of a power-of-two lane count, usable in constant context
package polar_decoder_pkg;

  localparam int unsigned LLR_W = 8;

  typedef logic signed [LLR_W-1:0] llr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } f_sched_state_t;

  // Smallest r with 2^r >= lanes.
  function automatic int unsigned lanes_log2(input int unsigned lanes);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < lanes) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_decoder_alpha.sv
// Min-sum f-function: y = sign(a)*sign(b)*min(|a|,|b|).
// Ports:
//   a, b : two's complement LLR inputs (WIDTH bits)
//   y    : combinational result (WIDTH bits)
// The most negative code is never presented by the upstream datapath.
module polar_decoder_alpha #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag_min;
  logic             neg;

  // Magnitudes, minimum, then reapply the combined sign.
  always_comb begin
    mag_a   = a[WIDTH-1] ? WIDTH'(~a + 1'b1) : a;
    mag_b   = b[WIDTH-1] ? WIDTH'(~b + 1'b1) : b;
    mag_min = (mag_a < mag_b) ? mag_a : mag_b;
    neg     = a[WIDTH-1] ^ b[WIDTH-1];
    y       = neg ? WIDTH'(~mag_min + 1'b1) : mag_min;
  end

endmodule

// File: rtl/polar_decoder_f_sched.sv
// Layer scheduler for the SC decoder f-step. Streams the left and right halves
// of a 2^log_n LLR node out of the LLR RAM, passes them through LANES alpha
// units and writes the 2^(log_n-1) results to a destination region.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, log_n, src_base,
//   dst_base, abort          : job request / cancel from the tree controller
//   busy, done, err          : job status (done/err are one-cycle pulses)
//   rd_en, rd_addr_l/r       : read strobe and addresses, both RAM read ports
//   rd_data_l/r              : read data, valid the cycle after rd_en
//   wr_en, wr_addr, wr_data  : result write port
module polar_decoder_f_sched
  import polar_decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_LOG_N = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_LOG_N+1)-1:0] log_n,
  input  logic [ADDR_W-1:0]            src_base,
  input  logic [ADDR_W-1:0]            dst_base,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr_l,
  output logic [ADDR_W-1:0]            rd_addr_r,
  input  logic [LANES*WIDTH-1:0]       rd_data_l,
  input  logic [LANES*WIDTH-1:0]       rd_data_r,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [LANES*WIDTH-1:0]       wr_data
);

  localparam int unsigned LG    = lanes_log2(LANES);
  localparam int unsigned CNT_W = MAX_LOG_N - LG;
  localparam int unsigned DW    = LANES * WIDTH;

  f_sched_state_t state, next_state;

  // Job context and word counter.
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  w_q, w_d;
  logic [CNT_W-1:0]  k_q, k_d;

  // Next values of the registered outputs.
  logic              busy_d, done_d, err_d, rd_en_d, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_l_d, rd_addr_r_d, wr_addr_d;

  logic              legal_in;
  logic [CNT_W-1:0]  words_in;
  logic              last_issue;
  logic              accept;
  logic [CNT_W-1:0]  k_next;
  logic [DW-1:0]     alpha_w;

  // Request decode: legal range and word count W = 2^(log_n-1)/LANES.
  always_comb begin
    legal_in = (32'(log_n) >= LG + 1) && (32'(log_n) <= MAX_LOG_N);
    words_in = legal_in ? (CNT_W'(1) << (32'(log_n) - (LG + 1))) : '0;
    accept   = (state == IDLE) && start && !abort;
    last_issue = (k_q == w_q - CNT_W'(1));
    k_next   = k_q + CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = legal_in ? RUN : DONE;
      RUN:   if (abort) next_state = IDLE;
             else if (last_issue) next_state = DRAIN;
      DRAIN: next_state = abort ? IDLE : DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath next values. Writes trail reads by the RAM latency.
  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    w_d         = w_q;
    k_d         = k_q;
    rd_en_d     = 1'b0;
    rd_addr_l_d = rd_addr_l;
    rd_addr_r_d = rd_addr_r;
    wr_en_d     = rd_en && !abort;
    wr_addr_d   = rd_en ? (dst_q + ADDR_W'(k_q)) : wr_addr;
    busy_d      = (next_state == RUN) || (next_state == DRAIN);
    done_d      = (next_state == DONE);
    err_d       = accept && !legal_in;

    unique case (state)
      IDLE: begin
        if (accept) begin
          src_d = src_base;
          dst_d = dst_base;
          w_d   = words_in;
          k_d   = '0;
          if (legal_in) begin
            rd_en_d     = 1'b1;
            rd_addr_l_d = src_base;
            rd_addr_r_d = src_base + ADDR_W'(words_in);
          end
        end
      end
      RUN: begin
        if (!abort && !last_issue) begin
          k_d         = k_next;
          rd_en_d     = 1'b1;
          rd_addr_l_d = src_q + ADDR_W'(k_next);
          rd_addr_r_d = src_q + ADDR_W'(w_q) + ADDR_W'(k_next);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and job context.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_l <= '0;
      rd_addr_r <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      w_q       <= '0;
      k_q       <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      rd_en     <= rd_en_d;
      rd_addr_l <= rd_addr_l_d;
      rd_addr_r <= rd_addr_r_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      w_q       <= w_d;
      k_q       <= k_d;
    end
  end

  // One alpha unit per lane, fed straight from the RAM read registers.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    polar_decoder_alpha #(.WIDTH(WIDTH)) u_alpha (
      .a (rd_data_l[i*WIDTH +: WIDTH]),
      .b (rd_data_r[i*WIDTH +: WIDTH]),
      .y (alpha_w[i*WIDTH +: WIDTH])
    );
  end

  // The RAM output register is the pipeline stage; result is masked outside writes.
  assign wr_data = wr_en ? alpha_w : '0;

endmodule

// File: tb/tb_polar_decoder_f_sched.sv
module tb_polar_decoder_f_sched;
  import polar_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  log_n;
  logic [9:0]  src_base;
  logic [9:0]  dst_base;
  logic        abort;
  logic        busy, done, err;
  logic        rd_en;
  logic [9:0]  rd_addr_l, rd_addr_r;
  logic [63:0] rd_data_l, rd_data_r;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;

  always #5 clk = ~clk;

  polar_decoder_f_sched dut (
    .clk(clk), .rst(rst), .start(start), .log_n(log_n),
    .src_base(src_base), .dst_base(dst_base), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_l(rd_addr_l), .rd_addr_r(rd_addr_r),
    .rd_data_l(rd_data_l), .rd_data_r(rd_data_r),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // LLR RAM model: one-cycle registered read on both ports.
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_data_l <= mem[rd_addr_l];
      rd_data_r <= mem[rd_addr_r];
    end
  end

  typedef struct packed { logic [9:0] l; logic [9:0] r; } rd_t;
  typedef struct packed { logic [9:0] a; logic [63:0] d; } wr_t;
  rd_t exp_rd[$];
  wr_t exp_wr[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Min-sum reference from the definition.
  function automatic llr_t f_ref(input llr_t a, input llr_t b);
    llr_t ma, mb, m;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    m  = (ma < mb) ? ma : mb;
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  function automatic logic [63:0] f_word(input logic [63:0] l, input logic [63:0] r);
    logic [63:0] o;
    for (int i = 0; i < 8; i++) o[i*8 +: 8] = f_ref(llr_t'(l[i*8 +: 8]), llr_t'(r[i*8 +: 8]));
    return o;
  endfunction

  // Scoreboard: every RAM access the DUT makes must match the next expected one.
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      if (exp_rd.size() == 0) chk("unexpected_rd", {44'd0, rd_addr_l, rd_addr_r}, 64'd0);
      else begin
        rd_t e;
        e = exp_rd.pop_front();
        chk("rd_addr_l", 64'(rd_addr_l), 64'(e.l));
        chk("rd_addr_r", 64'(rd_addr_r), 64'(e.r));
      end
    end
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) chk("unexpected_wr", 64'(wr_addr), 64'h3ff_ffff);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.a));
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  // Alpha lane vectors, placed in lanes 0..7 of words 0x10 (left) / 0x11 (right).
  typedef struct { llr_t a; llr_t b; llr_t y; } lane_vec_t;
  lane_vec_t lv [8];

  // Job table: expected done latency and err derived from the node size.
  typedef struct { int ln; logic [9:0] src; logic [9:0] dst; int poke; bit tbl; int exp_cyc; bit exp_err; } job_t;
  job_t jobs [8];

  logic [63:0] tbl_word;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_job(input int ln, input logic [9:0] src, input logic [9:0] dst,
                          input bit tbl, input int nwords);
    int w;
    w = 1 << (ln - 4);
    for (int k = 0; k < nwords; k++) begin
      logic [9:0] al, ar, ad;
      al = src + 10'(k);
      ar = src + 10'(w) + 10'(k);
      ad = dst + 10'(k);
      exp_rd.push_back('{l: al, r: ar});
    end
    for (int k = 0; k < nwords; k++) begin
      logic [9:0] al, ar, ad;
      al = src + 10'(k);
      ar = src + 10'(w) + 10'(k);
      ad = dst + 10'(k);
      if (k < nwords - ((nwords < w) ? 1 : 0))
        exp_wr.push_back('{a: ad, d: tbl ? tbl_word : f_word(mem[al], mem[ar])});
    end
  endtask

  task automatic run_job(input job_t j);
    bit legal;
    int w, done_cyc;
    legal = (j.ln >= 4) && (j.ln <= 10);
    w = legal ? (1 << (j.ln - 4)) : 0;
    if (legal) push_job(j.ln, j.src, j.dst, j.tbl, w);
    log_n = 4'(j.ln); src_base = j.src; dst_base = j.dst; start = 1'b1;
    step();
    start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == j.poke) begin
        start = 1'b1; log_n = 4'd4;
        src_base = j.src + 10'h155; dst_base = j.dst ^ 10'h2aa;
      end else start = 1'b0;
      chk($sformatf("busy_ln%0d_c%0d", j.ln, c), 64'(busy), 64'(legal && c <= w + 1));
      if (done === 1'b1) begin
        done_cyc = c;
        chk($sformatf("err_ln%0d", j.ln), 64'(err), 64'(j.exp_err));
        break;
      end
      step();
    end
    start = 1'b0;
    chk($sformatf("done_cycle_ln%0d", j.ln), 64'(done_cyc), 64'(j.exp_cyc));
    step();
    chk("done_after", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    exp_rd.delete(); exp_wr.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_rd_addr_l"}, 64'(rd_addr_l), 64'd0);
    chk({tag, "_rd_addr_r"}, 64'(rd_addr_r), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, wr_data, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    log_n = '0; src_base = '0; dst_base = '0;

    for (int a = 0; a < 1024; a++) begin
      logic [63:0] wv;
      for (int i = 0; i < 8; i++) begin
        int v;
        v = int'($urandom_range(254)) - 127;
        wv[i*8 +: 8] = 8'(v);
      end
      mem[a] = wv;
    end

    lv[0] = '{a:  5,   b: -2,   y: -2};
    lv[1] = '{a: -3,   b: -6,   y:  3};
    lv[2] = '{a:  7,   b:  4,   y:  4};
    lv[3] = '{a: -1,   b:  0,   y:  0};
    lv[4] = '{a: 127,  b: -127, y: -127};
    lv[5] = '{a: -127, b: -127, y:  127};
    lv[6] = '{a:  0,   b: -5,   y:  0};
    lv[7] = '{a: -64,  b: 100,  y: -64};
    for (int i = 0; i < 8; i++) begin
      mem[10'h010][i*8 +: 8] = lv[i].a;
      mem[10'h011][i*8 +: 8] = lv[i].b;
      tbl_word[i*8 +: 8]     = lv[i].y;
    end

    jobs[0] = '{ln: 4,  src: 10'h010, dst: 10'h040, poke: 0, tbl: 1'b1, exp_cyc: 3,  exp_err: 1'b0};
    jobs[1] = '{ln: 6,  src: 10'h3fe, dst: 10'h100, poke: 0, tbl: 1'b0, exp_cyc: 6,  exp_err: 1'b0};
    jobs[2] = '{ln: 3,  src: 10'h020, dst: 10'h050, poke: 0, tbl: 1'b0, exp_cyc: 1,  exp_err: 1'b1};
    jobs[3] = '{ln: 11, src: 10'h020, dst: 10'h050, poke: 0, tbl: 1'b0, exp_cyc: 1,  exp_err: 1'b1};
    jobs[4] = '{ln: 5,  src: 10'h200, dst: 10'h3ff, poke: 0, tbl: 1'b0, exp_cyc: 4,  exp_err: 1'b0};
    jobs[5] = '{ln: 6,  src: 10'h0a0, dst: 10'h180, poke: 2, tbl: 1'b0, exp_cyc: 6,  exp_err: 1'b0};
    jobs[6] = '{ln: 10, src: 10'h300, dst: 10'h010, poke: 40, tbl: 1'b0, exp_cyc: 66, exp_err: 1'b0};
    jobs[7] = '{ln: 0,  src: 10'h000, dst: 10'h000, poke: 0, tbl: 1'b0, exp_cyc: 1,  exp_err: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_job(jobs[i]);

    // Abort in cycle 2 of a W=4 job: reads k0,k1 and the k0 write only.
    push_job(6, 10'h080, 10'h1c0, 1'b0, 2);
    log_n = 4'd6; src_base = 10'h080; dst_base = 10'h1c0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      chk($sformatf("abort_rd_en_c%0d", c), 64'(rd_en), 64'd0);
      chk($sformatf("abort_wr_en_c%0d", c), 64'(wr_en), 64'd0);
      chk($sformatf("abort_done_c%0d", c), 64'(done), 64'd0);
      chk($sformatf("abort_busy_c%0d", c), 64'(busy), 64'd0);
      step();
    end
    chk("abort_rd_queue", 64'(exp_rd.size()), 64'd0);
    chk("abort_wr_queue", 64'(exp_wr.size()), 64'd0);
    exp_rd.delete(); exp_wr.delete();
    run_job(jobs[1]);

    // start together with abort in IDLE: nothing happens.
    log_n = 4'd5; src_base = 10'h111; dst_base = 10'h222; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sa_busy_c%0d", c), 64'(busy), 64'd0);
      chk($sformatf("sa_done_c%0d", c), 64'(done), 64'd0);
      step();
    end

    // Synchronous reset mid-RUN.
    push_job(6, 10'h0c0, 10'h240, 1'b0, 2);
    log_n = 4'd6; src_base = 10'h0c0; dst_base = 10'h240; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    step();
    chk_reset_outputs("midrst_idle");
    chk("rst_rd_queue", 64'(exp_rd.size()), 64'd0);
    chk("rst_wr_queue", 64'(exp_wr.size()), 64'd0);
    exp_rd.delete(); exp_wr.delete();
    run_job(jobs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
